// File: rtl/mem_port_arbiter_if.sv
// Requester-side req/ack bus shared by the CPU and debug ports of the RAM arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 14
) ();
    logic                  req;
    logic                  we;
    logic [3:0]            wstrb;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  ack;
    logic [31:0]           rdata;

    modport master (
        output req, we, wstrb, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, wstrb, addr, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous RAM port between the CPU and a debug/boot requester.
// Round-robin or fixed CPU priority, with a debug bus-lock for multi-word loads.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 14,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     cpu,
    mem_port_arbiter_if.slave     dbg,
    input  logic                  dbg_lock,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [3:0]            mem_wstrb,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    output logic                  owner,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   grant_c;
    logic   grant_dbg_c;
    logic   lat_we;

    // Winner selection; lock only binds once debug already owns the bus
    always_comb begin
        state_nx    = state;
        grant_c     = 1'b0;
        grant_dbg_c = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_lock && owner) begin
                    grant_c     = dbg.req;
                    grant_dbg_c = 1'b1;
                end else if (cpu.req && dbg.req) begin
                    grant_c     = 1'b1;
                    grant_dbg_c = FIXED_PRIO ? 1'b0 : !owner;
                end else begin
                    grant_c     = cpu.req || dbg.req;
                    grant_dbg_c = dbg.req;
                end
                if (grant_c) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = CAPTURE;
            CAPTURE: state_nx = ACK;
            ACK:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Registered datapath: request latch, RAM strobes, read capture and acks
    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= 1'b1;
            busy      <= 1'b0;
            lat_we    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'd0;
            mem_addr  <= ADDR_WIDTH'(0);
            mem_wdata <= 32'd0;
            cpu.ack   <= 1'b0;
            dbg.ack   <= 1'b0;
            cpu.rdata <= 32'd0;
            dbg.rdata <= 32'd0;
        end else begin
            cpu.ack <= 1'b0;
            dbg.ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_c) begin
                        owner  <= grant_dbg_c;
                        busy   <= 1'b1;
                        mem_en <= 1'b1;
                        if (grant_dbg_c) begin
                            lat_we    <= dbg.we;
                            mem_we    <= dbg.we;
                            mem_wstrb <= dbg.we ? dbg.wstrb : 4'd0;
                            mem_addr  <= dbg.addr;
                            mem_wdata <= dbg.wdata;
                        end else begin
                            lat_we    <= cpu.we;
                            mem_we    <= cpu.we;
                            mem_wstrb <= cpu.we ? cpu.wstrb : 4'd0;
                            mem_addr  <= cpu.addr;
                            mem_wdata <= cpu.wdata;
                        end
                    end
                end
                ACCESS: begin
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= 4'd0;
                end
                CAPTURE: begin
                    if (!lat_we) begin
                        if (owner) begin
                            dbg.rdata <= mem_rdata;
                        end else begin
                            cpu.rdata <= mem_rdata;
                        end
                    end
                    if (owner) begin
                        dbg.ack <= 1'b1;
                    end else begin
                        cpu.ack <= 1'b1;
                    end
                end
                ACK: begin
                    busy <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin instance plus a fixed-priority twin driven by the same requests.
module tb_mem_port_arbiter;
    localparam int unsigned AW = 14;

    logic clk = 1'b0;
    logic reset;
    logic dbg_lock;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) cpu_if ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) dbg_if ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) f_cpu_if ();
    mem_port_arbiter_if #(.ADDR_WIDTH(AW)) f_dbg_if ();

    logic          mem_en, mem_we, owner, busy;
    logic [3:0]    mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic          f_mem_en, f_mem_we, f_owner, f_busy;
    logic [3:0]    f_mem_wstrb;
    logic [AW-1:0] f_mem_addr;
    logic [31:0]   f_mem_wdata, f_mem_rdata;

    logic [31:0] ram0 [0:255];
    logic [31:0] ram1 [0:255];

    int n_cmp = 0;
    int n_err = 0;

    assign f_cpu_if.req   = cpu_if.req;
    assign f_cpu_if.we    = cpu_if.we;
    assign f_cpu_if.wstrb = cpu_if.wstrb;
    assign f_cpu_if.addr  = cpu_if.addr;
    assign f_cpu_if.wdata = cpu_if.wdata;
    assign f_dbg_if.req   = dbg_if.req;
    assign f_dbg_if.we    = dbg_if.we;
    assign f_dbg_if.wstrb = dbg_if.wstrb;
    assign f_dbg_if.addr  = dbg_if.addr;
    assign f_dbg_if.wdata = dbg_if.wdata;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset), .cpu(cpu_if), .dbg(dbg_if), .dbg_lock(dbg_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .owner(owner), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .reset(reset), .cpu(f_cpu_if), .dbg(f_dbg_if), .dbg_lock(dbg_lock),
        .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_wstrb(f_mem_wstrb), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_rdata(f_mem_rdata), .owner(f_owner), .busy(f_busy)
    );

    // Synchronous RAM models, reloaded with known words during reset
    always @(posedge clk) begin
        if (reset) begin
            ram0[16] <= 32'hDEAD_BEEF;
            ram0[32] <= 32'hAAAA_AAAA;
            ram0[48] <= 32'hCAFE_F00D;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we && mem_wstrb[b]) ram0[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram0[mem_addr[7:0]];
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            ram1[16] <= 32'hDEAD_BEEF;
            ram1[32] <= 32'hAAAA_AAAA;
            ram1[48] <= 32'hCAFE_F00D;
        end else if (f_mem_en) begin
            for (int b = 0; b < 4; b++)
                if (f_mem_we && f_mem_wstrb[b]) ram1[f_mem_addr[7:0]][8*b +: 8] <= f_mem_wdata[8*b +: 8];
            f_mem_rdata <= ram1[f_mem_addr[7:0]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0: DUT just reset, inputs idle
    task automatic do_reset();
        reset        = 1'b1;
        dbg_lock     = 1'b0;
        cpu_if.req   = 1'b0;
        cpu_if.we    = 1'b0;
        cpu_if.wstrb = 4'd0;
        cpu_if.addr  = '0;
        cpu_if.wdata = 32'd0;
        dbg_if.req   = 1'b0;
        dbg_if.we    = 1'b0;
        dbg_if.wstrb = 4'd0;
        dbg_if.addr  = '0;
        dbg_if.wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst busy", 32'(busy), 32'd0);
        check("rst owner", 32'(owner), 32'd1);
        check("rst mem_en", 32'(mem_en), 32'd0);
        check("rst mem_we", 32'(mem_we), 32'd0);
        check("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst mem_addr", 32'(mem_addr), 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst cpu_ack", 32'(cpu_if.ack), 32'd0);
        check("rst dbg_ack", 32'(dbg_if.ack), 32'd0);
        check("rst cpu_rdata", cpu_if.rdata, 32'd0);
        check("rst dbg_rdata", dbg_if.rdata, 32'd0);

        // CPU read of 0x010
        cpu_if.req  = 1'b1;
        cpu_if.addr = AW'(16);
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("rd mem_en c%0d", c), 32'(mem_en), 32'(c == 1));
            check($sformatf("rd cpu_ack c%0d", c), 32'(cpu_if.ack), 32'(c == 3));
            check($sformatf("rd dbg_ack c%0d", c), 32'(dbg_if.ack), 32'd0);
            if (c == 1) begin
                check("rd mem_addr", 32'(mem_addr), 32'h010);
                check("rd mem_we", 32'(mem_we), 32'd0);
                check("rd mem_wstrb", 32'(mem_wstrb), 32'd0);
                check("rd owner", 32'(owner), 32'd0);
                check("rd busy", 32'(busy), 32'd1);
            end
            if (c == 3) check("rd cpu_rdata", cpu_if.rdata, 32'hDEAD_BEEF);
            if (c == 5) begin
                check("rd idle busy", 32'(busy), 32'd0);
                check("rd cpu_rdata held", cpu_if.rdata, 32'hDEAD_BEEF);
            end
            if (c == 4) cpu_if.req = 1'b0;
        end

        // Debug partial write to 0x020
        do_reset();
        dbg_if.req   = 1'b1;
        dbg_if.we    = 1'b1;
        dbg_if.wstrb = 4'b0011;
        dbg_if.addr  = AW'(32);
        dbg_if.wdata = 32'h1234_5678;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check($sformatf("wr mem_en c%0d", c), 32'(mem_en), 32'(c == 1));
            check($sformatf("wr dbg_ack c%0d", c), 32'(dbg_if.ack), 32'(c == 3));
            check($sformatf("wr cpu_ack c%0d", c), 32'(cpu_if.ack), 32'd0);
            if (c == 1) begin
                check("wr mem_we", 32'(mem_we), 32'd1);
                check("wr mem_wstrb", 32'(mem_wstrb), 32'b0011);
                check("wr mem_addr", 32'(mem_addr), 32'h020);
                check("wr mem_wdata", mem_wdata, 32'h1234_5678);
                check("wr owner", 32'(owner), 32'd1);
            end
            if (c == 3) check("wr dbg_rdata", dbg_if.rdata, 32'd0);
            if (c == 5) check("wr ram", ram0[32], 32'hAAAA_5678);
            if (c == 4) dbg_if.req = 1'b0;
        end

        // Both requesting reads: round-robin alternates, fixed priority always serves CPU
        do_reset();
        cpu_if.req  = 1'b1;
        cpu_if.addr = AW'(16);
        dbg_if.req  = 1'b1;
        dbg_if.addr = AW'(48);
        for (int c = 1; c <= 16; c++) begin
            tick();
            check($sformatf("rr cpu_ack c%0d", c), 32'(cpu_if.ack), 32'(c == 3 || c == 11));
            check($sformatf("rr dbg_ack c%0d", c), 32'(dbg_if.ack), 32'(c == 7 || c == 15));
            check($sformatf("rr owner c%0d", c), 32'(owner), 32'(((c - 1) / 4) % 2));
            check($sformatf("fp cpu_ack c%0d", c), 32'(f_cpu_if.ack), 32'(c % 4 == 3));
            check($sformatf("fp dbg_ack c%0d", c), 32'(f_dbg_if.ack), 32'd0);
            if (c == 5) check("rr mem_addr dbg", 32'(mem_addr), 32'h030);
            if (c == 7) begin
                check("rr dbg_rdata", dbg_if.rdata, 32'hCAFE_F00D);
                check("rr cpu_rdata held", cpu_if.rdata, 32'hDEAD_BEEF);
            end
            if (c == 16) begin
                cpu_if.req = 1'b0;
                dbg_if.req = 1'b0;
            end
        end

        // Debug lock across three writes while the CPU waits
        do_reset();
        cpu_if.req   = 1'b1;
        cpu_if.addr  = AW'(16);
        dbg_lock     = 1'b1;
        dbg_if.req   = 1'b1;
        dbg_if.we    = 1'b1;
        dbg_if.wstrb = 4'hF;
        dbg_if.addr  = AW'(64);
        dbg_if.wdata = 32'h1000_0000;
        for (int c = 1; c <= 18; c++) begin
            tick();
            check($sformatf("lk cpu_ack c%0d", c), 32'(cpu_if.ack), 32'(c == 17));
            check($sformatf("lk dbg_ack c%0d", c), 32'(dbg_if.ack), 32'(c == 3 || c == 7 || c == 11));
            check($sformatf("lk mem_en c%0d", c), 32'(mem_en), 32'(c == 1 || c == 5 || c == 9 || c == 15));
            if (c == 9) begin
                check("lk mem_addr", 32'(mem_addr), 32'h042);
                check("lk mem_wdata", mem_wdata, 32'h1000_0002);
            end
            if (c == 13) check("lk held idle busy", 32'(busy), 32'd0);
            if (c == 15) check("lk cpu mem_addr", 32'(mem_addr), 32'h010);
            if (c == 17) check("lk cpu_rdata", cpu_if.rdata, 32'hDEAD_BEEF);
            if (c == 4 || c == 8) begin
                dbg_if.addr  = AW'(64 + c / 4);
                dbg_if.wdata = 32'h1000_0000 + 32'(c / 4);
            end
            if (c == 12) dbg_if.req = 1'b0;
            if (c == 14) dbg_lock = 1'b0;
            if (c == 18) cpu_if.req = 1'b0;
        end

        // Reset during CAPTURE of a CPU read, then re-issue
        do_reset();
        cpu_if.req  = 1'b1;
        cpu_if.addr = AW'(16);
        for (int c = 1; c <= 7; c++) begin
            tick();
            if (c == 3) begin
                check("mr busy", 32'(busy), 32'd0);
                check("mr owner", 32'(owner), 32'd1);
                check("mr cpu_rdata", cpu_if.rdata, 32'd0);
                check("mr mem_en", 32'(mem_en), 32'd0);
                reset = 1'b0;
            end
            check($sformatf("mr cpu_ack c%0d", c), 32'(cpu_if.ack), 32'(c == 6));
            if (c == 6) check("mr cpu_rdata reissue", cpu_if.rdata, 32'hDEAD_BEEF);
            if (c == 2) reset = 1'b1;
            if (c == 7) cpu_if.req = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
